// File: rtl/pix_unpack_pkg.sv
// pix_unpack shared definitions.
// Field modes, widths and buffer sizing.
package pix_unpack_pkg;

  localparam int WORD_W = 32;
  localparam int BUF_W  = 64;
  localparam int CNT_W  = 7;

  localparam logic [CNT_W-1:0] W8  = 7'd8;
  localparam logic [CNT_W-1:0] W16 = 7'd16;
  localparam logic [CNT_W-1:0] W24 = 7'd24;
  localparam logic [CNT_W-1:0] WRD = 7'd32;

  typedef enum logic [1:0] {
    MODE8  = 2'd0,
    MODE16 = 2'd1,
    MODE24 = 2'd2
  } mode_t;

  function automatic mode_t mode_of(
    input logic sixteen,
    input logic twentyfour
  );
    mode_t m;
    m = MODE8;
    if (twentyfour)
      m = MODE24;
    else if (sixteen)
      m = MODE16;
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] width_of(
    input mode_t m
  );
    logic [CNT_W-1:0] w;
    w = W8;
    unique case (1'b1)
      (m == MODE24): w = W24;
      (m == MODE16): w = W16;
      default:       w = W8;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pix_unpack_if.sv
// pix_unpack stream interface.
// Word input side plus element output side.
interface pix_unpack_if;
  import pix_unpack_pkg::*;

  logic [WORD_W-1:0] d;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] q;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output d,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  q,
    input  out_valid
  );

  modport slave (
    input  d,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output q,
    output out_valid
  );

endinterface

// File: rtl/pix_unpack_extend.sv
// pix_extend: picks the low field of the buffer
// and zero- or sign-extends it to a word.
module pix_extend
  import pix_unpack_pkg::*;
(
  input  logic [23:0]       lo,
  input  mode_t             mode,
  input  logic              sext,
  output logic [WORD_W-1:0] q
);

  // field select and extension
  always_comb begin
    q = '0;
    unique case (1'b1)
      (mode == MODE24):
        q = {{8{sext & lo[23]}}, lo[23:0]};
      (mode == MODE16):
        q = {{16{sext & lo[15]}}, lo[15:0]};
      default:
        q = {{24{sext & lo[7]}}, lo[7:0]};
    endcase
  end

endmodule

// File: rtl/pix_unpack.sv
// pix_unpack: packed-field word to element stream.
// 64-bit residue buffer, one element per handshake.
module pix_unpack
  import pix_unpack_pkg::*;
(
  input  logic         sys_clk,
  input  logic         resetl,
  input  logic         sixteen,
  input  logic         twentyfour,
  input  logic         sext,
  input  logic         flush,
  pix_unpack_if.slave  s
);

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  mode_t            mode_r;
  logic             sext_r;

  mode_t            mode_in;
  mode_t            mode_w;
  logic [CNT_W-1:0] w;
  logic             emit;
  logic             acc;
  logic [BUF_W-1:0] shifted;
  logic [CNT_W-1:0] pos;

  assign mode_in = mode_of(sixteen, twentyfour);
  assign mode_w  = (cnt == '0) ? mode_in : mode_r;
  assign w       = width_of(mode_w);

  assign s.out_valid = (cnt >= w);
  assign s.in_ready  = ~flush & (cnt <= WRD);

  assign emit = s.out_valid & s.out_ready;
  assign acc  = s.in_valid & s.in_ready;

  // shift out the emitted field, append the accepted word
  always_comb begin
    shifted = buf_q;
    pos     = cnt;
    cnt_nx  = cnt;
    buf_nx  = buf_q;
    if (emit) begin
      shifted = buf_q >> w;
      pos     = cnt - w;
    end
    buf_nx = shifted;
    cnt_nx = pos;
    if (acc) begin
      buf_nx = shifted | ({{(BUF_W-WORD_W){1'b0}}, s.d} << pos);
      cnt_nx = pos + WRD;
    end
    if (flush) begin
      buf_nx = '0;
      cnt_nx = '0;
    end
  end

  // buffer and fill count
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      buf_q <= '0;
      cnt   <= '0;
    end else begin
      buf_q <= buf_nx;
      cnt   <= cnt_nx;
    end
  end

  // mode latches only while the buffer is empty
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      mode_r <= MODE8;
      sext_r <= 1'b0;
    end else if (cnt == '0) begin
      mode_r <= mode_in;
      sext_r <= sext;
    end
  end

  pix_extend u_ext (
    .lo   (buf_q[23:0]),
    .mode (mode_w),
    .sext (sext_r),
    .q    (s.q)
  );

endmodule

// File: doc/pix_unpack.md
# pix_unpack

Streaming pixel unpacker for the TOM arithmetic path: the inverse of the saturate-and-pack stage. It accepts 32-bit words holding packed 8-, 16- or 24-bit unsigned pixel fields and emits one zero- or sign-extended 32-bit element per handshake. It sits between the local RAM/load path and the GPU/blitter arithmetic.

## Interface
Parameters: none; widths are fixed by the shared package.
- sys_clk  in  1  system clock; all state changes on its rising edge
- resetl  in  1  asynchronous active-low reset
- d  in  32  packed input word; lowest field in bits 7:0 / 15:0 / 23:0
- in_valid  in  1  d is valid
- in_ready  out  1  word accepted when in_valid & in_ready
- sixteen  in  1  16-bit field mode
- twentyfour  in  1  24-bit field mode; wins if both set; neither = 8-bit mode
- sext  in  1  sign-extend fields (default zero-extend)
- flush  in  1  synchronous discard of buffered residue
- q  out  32  extended element
- out_valid  out  1  q is valid
- out_ready  in  1  element consumed when out_valid & out_ready

## Operation
- State: 64-bit buffer buf, 7-bit count cnt (0..64), latched mode_r (W = 8/16/24) and sext_r.
- Mode latch: on every cycle with cnt==0, mode_r/sext_r load from the inputs. W is taken from the inputs in that cycle and from mode_r otherwise. Mode inputs are ignored while cnt!=0.
- in_ready = ~flush & (cnt <= 32); derived from flops and flush only, never from out_ready.
- out_valid = (cnt >= W). q = buf[W-1:0], extended to 32 bits (bit W-1 replicated if sext_r, else zeros).
- Emit (out handshake): buf shifts right by W and cnt decreases by W.
- Accept (in handshake): d is written at bit position cnt (post-emit position if the emit fires in the same cycle), and cnt increases by 32.
- Simultaneous emit and accept: cnt_next = cnt + 32 − W, with d placed at cnt − W.
- 8-bit: 4 elements per word. 16-bit: 2 per word. 24-bit: 4 elements per 3 words, with residue 8, 16, then 0 bits.
- flush: in_ready is 0 this cycle. An emit handshake in the same cycle completes normally. Then cnt becomes 0 and buf is cleared. Residue below W bits is otherwise held indefinitely.
- Reset: cnt=0, buf=0, mode_r=8-bit, sext_r=0. Hence q=0, out_valid=0, in_ready=1.
- Reset asserted mid-stream discards all buffered data with no output handshake.

## Timing
- Latency: a word accepted in cycle n gives out_valid in cycle n+1 (first element).
- Throughput: 1 element/cycle sustained in all modes. Input stalls only when cnt > 32.
- q and out_valid are stable while out_valid & ~out_ready. No combinational path from in_valid/d to out_valid/q.
- Boundary: at cnt=32 in 8-bit mode with no emit, an accept fills cnt to 64 (full); in_ready=0 until cnt ≤ 32.

## Structure
- Package pix_unpack_pkg: W8/W16/W24 constants, 2-bit mode encoding (MODE8, MODE16, MODE24), BUF_W=64, CNT_W=7.
- One combinational sub-module, pix_extend (W-select plus zero/sign extension of buf low bits). Everything else lives in pix_unpack.

## Test plan
- 8-bit, sext=0, d=0x80FF7F01, out_ready=1 → q = 0x01, 0x7F, 0xFF, 0x80 on four consecutive cycles; out_valid then drops.
- 8-bit, sext=1, same word → q = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
- 24-bit, words 0x44332211, 0x88776655, 0xCCBBAA99 back-to-back → q = 0x332211, 0x665544, 0x998877, 0xCCBBAA; cnt ends at 0.
- 16-bit, out_ready=0 for 5 cycles with in_valid held → two words accepted (cnt=64), in_ready=0. Release out_ready → q = the four halfwords in order, no loss or duplication.
- 24-bit, accept one word 0xDEADBEEF, consume 0xADBEEF, leaving 8 residue bits → out_valid=0. Assert flush one cycle → cnt=0. Then switch to 16-bit with d=0x12345678 → q = 0x5678, 0x1234.
- Drop resetl asynchronously with cnt=40 → in_ready=1, out_valid=0, q=0 immediately. No output after release until a new word arrives.
